// File: rtl/controller_pkg.sv
// Shared FSM state type and default width constants for the job controller.
package controller_pkg;

    localparam int default_global_buf_addr_width = 13;
    localparam int default_bank                  = 32;
    localparam int default_log_bank              = 5;
    localparam int default_microaddr_width       = 5;
    localparam int default_pe_col                = 16;

    // N_SAMPLE / OUTPUT_FEATURE_LENGTH width, and round counter width (R <= 512).
    localparam int len_width   = 13;
    localparam int round_width = 14;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_LOAD,
        SYSTOLIC,
        AGG,
        FIN
    } ctrl_state_e;

endpackage

// File: rtl/ctrl_addr_counter.sv
// Loadable, enable-increment counter that wraps modulo 2^width; load wins over enable.
module ctrl_addr_counter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [width-1:0] load_val,
    input  logic             en,
    input  logic [width-1:0] step,
    output logic [width-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + step;
        end
    end

endmodule

// File: rtl/controller.sv
// Job controller: stream N_SAMPLE words into the PFT, run the systolic pass, then R aggregation rounds.
// Define CONTROLLER_PERF_CNT_EN to add the perf_cycles busy-cycle counter output.
module controller
    import controller_pkg::*;
#(
    parameter int global_buf_addr_width = default_global_buf_addr_width,
    parameter int bank                  = default_bank,
    parameter int log_bank              = default_log_bank,
    parameter int microaddr_width       = default_microaddr_width,
    parameter int PE_COL                = default_pe_col
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic                                LOAD_DONE,
    input  logic                                systolic_done,
    input  logic                                aggregation_done,
    input  logic [len_width-1:0]                N_SAMPLE,
    input  logic [global_buf_addr_width-1:0]    INIT_INPUT_ADDR,
    input  logic [global_buf_addr_width-1:0]    INIT_OUTPUT_ADDR,
    input  logic [len_width-1:0]                OUTPUT_FEATURE_LENGTH,
    output logic                                load_data,
    output logic                                start_systolic,
    output logic                                start_aggregation,
    output logic                                done,
    output logic [global_buf_addr_width-1:0]    global_buf_raddr,
    output logic [global_buf_addr_width-1:0]    global_buf_waddr,
    output logic [log_bank+microaddr_width-1:0] PFT_waddr
`ifdef CONTROLLER_PERF_CNT_EN
    ,
    output logic [31:0]                         perf_cycles
`endif
);

    localparam int pft_width = log_bank + microaddr_width;

    ctrl_state_e state, state_next;

    logic                             load_data_d, start_systolic_d, start_aggregation_d, done_d;
    logic                             load_dly;
    logic [len_width-1:0]             n_q, issue_cnt;
    logic [round_width-1:0]           rounds_q, round, rounds_calc;
    logic [global_buf_addr_width-1:0] waddr_step;
    logic                             job_start, agg_hit, agg_last, agg_step, issue_last;

    assign job_start   = (state == IDLE) && start;
    assign agg_hit     = (state == AGG) && aggregation_done;
    assign agg_last    = agg_hit && (round == rounds_q - round_width'(1));
    assign agg_step    = agg_hit && !agg_last;
    assign issue_last  = (issue_cnt + len_width'(1)) == n_q;
    assign rounds_calc = round_width'((32'(OUTPUT_FEATURE_LENGTH) + PE_COL - 1) / PE_COL);
    // bank is a power of two, so this equals n_q >> log_bank.
    assign waddr_step  = global_buf_addr_width'(32'(n_q) / bank);

    // State register plus the registered copies of every control output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state             <= IDLE;
            load_data         <= 1'b0;
            start_systolic    <= 1'b0;
            start_aggregation <= 1'b0;
            done              <= 1'b0;
            load_dly          <= 1'b0;
        end else begin
            state             <= state_next;
            load_data         <= load_data_d;
            start_systolic    <= start_systolic_d;
            start_aggregation <= start_aggregation_d;
            done              <= done_d;
            load_dly          <= load_data;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        state_next = state;
        unique case (state)
            IDLE:      if (start) state_next = (N_SAMPLE == '0) ? WAIT_LOAD : LOAD;
            LOAD: begin
                if (LOAD_DONE)       state_next = SYSTOLIC;
                else if (issue_last) state_next = WAIT_LOAD;
            end
            WAIT_LOAD: if (LOAD_DONE) state_next = SYSTOLIC;
            SYSTOLIC:  if (systolic_done) state_next = (rounds_q == '0) ? FIN : AGG;
            AGG:       if (agg_last) state_next = FIN;
            FIN:       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they appear registered, one cycle after the trigger.
    always_comb begin
        load_data_d         = (state_next == LOAD);
        done_d              = (state_next == FIN);
        start_systolic_d    = (state_next == SYSTOLIC) && (state != SYSTOLIC);
        start_aggregation_d = ((state_next == AGG) && (state != AGG)) || agg_step;
    end

    // Job configuration is captured once at start; later input changes do not affect a running job.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_q      <= '0;
            rounds_q <= '0;
            round    <= '0;
        end else if (job_start) begin
            n_q      <= N_SAMPLE;
            rounds_q <= rounds_calc;
            round    <= '0;
        end else if (agg_hit) begin
            round    <= round + round_width'(1);
        end
    end

`ifdef CONTROLLER_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_cycles <= '0;
        end else if (job_start) begin
            perf_cycles <= '0;
        end else if (state != IDLE) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

    ctrl_addr_counter #(.width(len_width)) u_issue_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (job_start),
        .load_val ('0),
        .en       (load_data),
        .step     (len_width'(1)),
        .count    (issue_cnt)
    );

    ctrl_addr_counter #(.width(global_buf_addr_width)) u_raddr (
        .clk      (clk),
        .rstn     (rstn),
        .load     (job_start),
        .load_val (INIT_INPUT_ADDR),
        .en       (load_data),
        .step     (global_buf_addr_width'(1)),
        .count    (global_buf_raddr)
    );

    // PFT writes trail the reads by the one-cycle buffer latency.
    ctrl_addr_counter #(.width(pft_width)) u_pft_waddr (
        .clk      (clk),
        .rstn     (rstn),
        .load     (job_start),
        .load_val ('0),
        .en       (load_dly),
        .step     (pft_width'(1)),
        .count    (PFT_waddr)
    );

    ctrl_addr_counter #(.width(global_buf_addr_width)) u_waddr (
        .clk      (clk),
        .rstn     (rstn),
        .load     (job_start),
        .load_val (INIT_OUTPUT_ADDR),
        .en       (agg_step),
        .step     (waddr_step),
        .count    (global_buf_waddr)
    );

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: expected pulses are queued when stimulus is driven and matched by a monitor.
module tb_controller;

    localparam int aw = 13;
    localparam int pw = 10;

    localparam int EV_NONE = 0;
    localparam int EV_SYS  = 1;
    localparam int EV_AGG  = 2;
    localparam int EV_DONE = 3;

    localparam int P_START = 0;
    localparam int P_LOAD  = 1;
    localparam int P_SYS   = 2;
    localparam int P_AGG   = 3;

    typedef struct {
        int            kind;
        int            cyc;
        logic [aw-1:0] waddr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0, LOAD_DONE = 1'b0, systolic_done = 1'b0, aggregation_done = 1'b0;
    logic [12:0]   N_SAMPLE = '0, OUTPUT_FEATURE_LENGTH = '0;
    logic [aw-1:0] INIT_INPUT_ADDR = '0, INIT_OUTPUT_ADDR = '0;
    logic          load_data, start_systolic, start_aggregation, done;
    logic [aw-1:0] global_buf_raddr, global_buf_waddr;
    logic [pw-1:0] PFT_waddr;
`ifdef CONTROLLER_PERF_CNT_EN
    logic [31:0]   perf_cycles;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    controller dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .start                 (start),
        .LOAD_DONE             (LOAD_DONE),
        .systolic_done         (systolic_done),
        .aggregation_done      (aggregation_done),
        .N_SAMPLE              (N_SAMPLE),
        .INIT_INPUT_ADDR       (INIT_INPUT_ADDR),
        .INIT_OUTPUT_ADDR      (INIT_OUTPUT_ADDR),
        .OUTPUT_FEATURE_LENGTH (OUTPUT_FEATURE_LENGTH),
        .load_data             (load_data),
        .start_systolic        (start_systolic),
        .start_aggregation     (start_aggregation),
        .done                  (done),
        .global_buf_raddr      (global_buf_raddr),
        .global_buf_waddr      (global_buf_waddr),
        .PFT_waddr             (PFT_waddr)
`ifdef CONTROLLER_PERF_CNT_EN
        ,
        .perf_cycles           (perf_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue an expected output pulse; it must appear in the cycle after the edge that samples this stimulus.
    task automatic expect_ev(input int kind, input logic [aw-1:0] waddr);
        exp_t e;
        e.kind  = kind;
        e.cyc   = cyc + 1;
        e.waddr = waddr;
        sb.push_back(e);
    endtask

    task automatic pulse(input int which);
        case (which)
            P_START: start            = 1'b1;
            P_LOAD:  LOAD_DONE        = 1'b1;
            P_SYS:   systolic_done    = 1'b1;
            default: aggregation_done = 1'b1;
        endcase
        step(1);
        {start, LOAD_DONE, systolic_done, aggregation_done} = 4'b0;
    endtask

    task automatic observe(input int kind);
        exp_t e;
        int   exp_kind;
        exp_kind = (sb.size() != 0) ? sb[0].kind : EV_NONE;
        check("pulse_kind", 32'(kind), 32'(exp_kind));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("pulse_cycle", 32'(cyc), 32'(e.cyc));
            if (kind == EV_AGG) check("agg_waddr", 32'(global_buf_waddr), 32'(e.waddr));
        end
    endtask

    always @(negedge clk) begin
        if (start_systolic)    observe(EV_SYS);
        if (start_aggregation) observe(EV_AGG);
        if (done)              observe(EV_DONE);
    end

    initial begin
        int            s;
        int            t0;
        int            nload;
        int            first;
        int            done_cyc;
        logic [aw-1:0] wexp;

        // Reset held for 10 cycles: every output low.
        step(10);
        check("rst_load_data", 32'(load_data), 0);
        check("rst_start_systolic", 32'(start_systolic), 0);
        check("rst_start_aggregation", 32'(start_aggregation), 0);
        check("rst_done", 32'(done), 0);
        check("rst_raddr", 32'(global_buf_raddr), 0);
        check("rst_waddr", 32'(global_buf_waddr), 0);
        check("rst_pft_waddr", 32'(PFT_waddr), 0);
`ifdef CONTROLLER_PERF_CNT_EN
        check("rst_perf", perf_cycles, 0);
`endif
        rstn = 1'b1;
        step(2);

        // Job 1: 1024 words, 64 output features -> 4 rounds.
        N_SAMPLE = 13'd1024;
        INIT_INPUT_ADDR = '0;
        INIT_OUTPUT_ADDR = 13'h1800;
        OUTPUT_FEATURE_LENGTH = 13'd64;
        t0 = cyc;
        s = t0 + 1;
        pulse(P_START);
        nload = 0;
        first = -1;
        for (int i = 0; i < 1100; i++) begin
            if (i == 5) N_SAMPLE = 13'd7;
            if (load_data) begin
                nload++;
                if (first < 0) first = cyc;
            end
            if (cyc == s + 1024) check("pft_before_wrap", 32'(PFT_waddr), 1023);
            if (cyc == s + 1025) check("pft_after_wrap", 32'(PFT_waddr), 0);
            step(1);
        end
        check("j1_load_count", 32'(nload), 1024);
        check("j1_load_first", 32'(first), 32'(s));
        check("j1_raddr_end", 32'(global_buf_raddr), 1024);
        check("j1_pft_end", 32'(PFT_waddr), 0);

        step(t0 + 2000 - cyc);
        expect_ev(EV_SYS, '0);
        pulse(P_LOAD);
        step(1999);
        expect_ev(EV_AGG, 13'h1800);
        pulse(P_SYS);
        step(5);
        pulse(P_START);
        pulse(P_LOAD);
        step(3);
        check("j1_stray_start_load", 32'(load_data), 0);
        check("j1_stray_raddr", 32'(global_buf_raddr), 1024);
        for (int k = 1; k < 4; k++) begin
            step(4);
            wexp = 13'h1800 + 13'(32 * k);
            expect_ev(EV_AGG, wexp);
            pulse(P_AGG);
        end
        step(4);
        done_cyc = cyc + 1;
        expect_ev(EV_DONE, '0);
        pulse(P_AGG);
        step(5);
        check("j1_waddr_hold", 32'(global_buf_waddr), 32'h1860);
        check("j1_sb_drain", 32'(sb.size()), 0);
`ifdef CONTROLLER_PERF_CNT_EN
        check("j1_perf", perf_cycles, 32'(done_cyc - s + 1));
`endif

        // Job 2: zero output features, read address wraps past the top of the buffer.
        N_SAMPLE = 13'd40;
        INIT_INPUT_ADDR = 13'h1FF0;
        INIT_OUTPUT_ADDR = 13'h0100;
        OUTPUT_FEATURE_LENGTH = 13'd0;
        s = cyc + 1;
        pulse(P_START);
        step(50);
        check("j2_raddr_wrap", 32'(global_buf_raddr), 32'h0018);
        check("j2_load_off", 32'(load_data), 0);
        check("j2_pft", 32'(PFT_waddr), 40);
        expect_ev(EV_SYS, '0);
        pulse(P_LOAD);
        step(3);
        done_cyc = cyc + 1;
        expect_ev(EV_DONE, '0);
        pulse(P_SYS);
        step(4);
        check("j2_sb_drain", 32'(sb.size()), 0);
        check("j2_waddr", 32'(global_buf_waddr), 32'h0100);
`ifdef CONTROLLER_PERF_CNT_EN
        check("j2_perf", perf_cycles, 32'(done_cyc - s + 1));
        step(5);
        check("j2_perf_stable", perf_cycles, 32'(done_cyc - s + 1));
`endif

        // Job 3: no samples (no strobe), two rounds with zero waddr step, stray aggregation_done ignored.
        N_SAMPLE = 13'd0;
        INIT_INPUT_ADDR = 13'h0123;
        INIT_OUTPUT_ADDR = 13'h0AAA;
        OUTPUT_FEATURE_LENGTH = 13'd17;
        pulse(P_START);
        nload = 0;
        for (int i = 0; i < 5; i++) begin
            if (load_data) nload++;
            step(1);
        end
        check("j3_no_strobe", 32'(nload), 0);
        check("j3_raddr", 32'(global_buf_raddr), 32'h0123);
        pulse(P_AGG);
        expect_ev(EV_SYS, '0);
        pulse(P_LOAD);
        step(2);
        pulse(P_AGG);
        step(2);
        expect_ev(EV_AGG, 13'h0AAA);
        pulse(P_SYS);
        step(3);
        expect_ev(EV_AGG, 13'h0AAA);
        pulse(P_AGG);
        step(3);
        expect_ev(EV_DONE, '0);
        pulse(P_AGG);
        step(3);
        check("j3_sb_drain", 32'(sb.size()), 0);
        check("j3_pft", 32'(PFT_waddr), 0);

        // Job 4: LOAD_DONE abandons the load after 10 words; single round.
        N_SAMPLE = 13'd100;
        INIT_INPUT_ADDR = 13'h0050;
        INIT_OUTPUT_ADDR = 13'h0200;
        OUTPUT_FEATURE_LENGTH = 13'd16;
        pulse(P_START);
        step(9);
        expect_ev(EV_SYS, '0);
        pulse(P_LOAD);
        step(2);
        check("j4_load_abandon", 32'(load_data), 0);
        check("j4_raddr", 32'(global_buf_raddr), 32'h005A);
        check("j4_pft", 32'(PFT_waddr), 10);
        step(3);
        expect_ev(EV_AGG, 13'h0200);
        pulse(P_SYS);
        step(3);
        expect_ev(EV_DONE, '0);
        pulse(P_AGG);
        step(3);
        check("j4_sb_drain", 32'(sb.size()), 0);

        // Job 5: asynchronous reset in the middle of LOAD.
        N_SAMPLE = 13'd100;
        INIT_INPUT_ADDR = 13'h0300;
        pulse(P_START);
        step(10);
        check("j5_loading", 32'(load_data), 1);
        rstn = 1'b0;
        #2;
        check("j5_rst_load_data", 32'(load_data), 0);
        check("j5_rst_raddr", 32'(global_buf_raddr), 0);
        check("j5_rst_pft", 32'(PFT_waddr), 0);
        step(3);
        rstn = 1'b1;
        step(5);
        check("j5_no_resume", 32'(load_data), 0);
        check("j5_raddr_idle", 32'(global_buf_raddr), 0);
`ifdef CONTROLLER_PERF_CNT_EN
        check("j5_perf_rst", perf_cycles, 0);
`endif

        check("final_sb_drain", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
